// File: rtl/dct_row_scheduler_if.sv
// Row-fetch bus between the DCT row scheduler and the IMG ROM / row multiplier.
// The scheduler uses the master side; the multiplier (and bench) use the slave side.
interface dct_row_scheduler_if;
    logic [15:0] img_addr_a;
    logic [15:0] img_addr_b;
    logic        fetch_vld;
    logic [1:0]  fetch_pair;
    logic        row_valid;
    logic        row_ready;
    logic [2:0]  row_idx;
    logic [4:0]  blk_x;
    logic [4:0]  blk_y;

    modport master (
        output img_addr_a, img_addr_b, fetch_vld, fetch_pair,
        output row_valid, row_idx, blk_x, blk_y,
        input  row_ready
    );

    modport slave (
        input  img_addr_a, img_addr_b, fetch_vld, fetch_pair,
        input  row_valid, row_idx, blk_x, blk_y,
        output row_ready
    );
endinterface

// File: rtl/dct_row_scheduler.sv
// Walks an IMG_W x IMG_H image in 8x8 blocks, fetching each 8-pixel row as four pixel pairs.
// Optional feature: define DCT_SCHED_STALL_CNT_EN to add the 32-bit stall_cycles counter output.
module dct_row_scheduler #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    dct_row_scheduler_if.master         bus,
    output logic                        busy,
    output logic                        done
`ifdef DCT_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cycles
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [4:0] BX_LAST = 5'(IMG_W / 8 - 1);
    localparam logic [4:0] BY_LAST = 5'(IMG_H / 8 - 1);

    logic [2:0]  state, state_nxt;
    logic [1:0]  k, k_nxt;
    logic [2:0]  row, row_nxt;
    logic [4:0]  bx, bx_nxt;
    logic [4:0]  by, by_nxt;
    logic [15:0] line_nxt;
    logic [15:0] addr_nxt;
    logic [15:0] addr_a_p0, addr_b_p0;
    logic        fetch_vld_p1;
    logic [1:0]  fetch_pair_p1;

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        row_nxt   = row;
        bx_nxt    = bx;
        by_nxt    = by;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_FETCH;
                    k_nxt     = 2'd0;
                    row_nxt   = 3'd0;
                    bx_nxt    = 5'd0;
                    by_nxt    = 5'd0;
                end
            end
            S_FETCH: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (k == 2'd3)
                    state_nxt = S_WAIT;
                else
                    k_nxt = k + 2'd1;
            end
            S_WAIT: state_nxt = abort ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                // abort wins over a simultaneous row_ready: the row is not consumed
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (bus.row_ready) begin
                    k_nxt     = 2'd0;
                    state_nxt = S_FETCH;
                    if (row != 3'd7) begin
                        row_nxt = row + 3'd1;
                    end else begin
                        row_nxt = 3'd0;
                        if (bx != BX_LAST) begin
                            bx_nxt = bx + 5'd1;
                        end else begin
                            bx_nxt = 5'd0;
                            if (by != BY_LAST) begin
                                by_nxt = by + 5'd1;
                            end else begin
                                by_nxt    = 5'd0;
                                state_nxt = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // by*8+row is the image line; the product wraps modulo 2^16 by construction
    assign line_nxt = {8'd0, by_nxt, row_nxt};
    assign addr_nxt = line_nxt * 16'(IMG_W) + {8'd0, bx_nxt, 3'd0} + {13'd0, k_nxt, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            k             <= 2'd0;
            row           <= 3'd0;
            bx            <= 5'd0;
            by            <= 5'd0;
            addr_a_p0     <= 16'd0;
            addr_b_p0     <= 16'd0;
            fetch_vld_p1  <= 1'b0;
            fetch_pair_p1 <= 2'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            row   <= row_nxt;
            bx    <= bx_nxt;
            by    <= by_nxt;
            // stage p0: address presented to the ROM during FETCH, held otherwise
            if (state_nxt == S_FETCH) begin
                addr_a_p0 <= addr_nxt;
                addr_b_p0 <= addr_nxt + 16'd1;
            end
            // stage p1: ROM data returns one cycle after its address
            fetch_vld_p1  <= (state == S_FETCH) && !abort;
            fetch_pair_p1 <= k;
        end
    end

    assign bus.img_addr_a = addr_a_p0;
    assign bus.img_addr_b = addr_b_p0;
    assign bus.fetch_vld  = fetch_vld_p1;
    assign bus.fetch_pair = fetch_pair_p1;
    assign bus.row_valid  = (state == S_ISSUE);
    assign bus.row_idx    = row;
    assign bus.blk_x      = bx;
    assign bus.blk_y      = by;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);

`ifdef DCT_SCHED_STALL_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= 32'd0;
        else if ((state == S_IDLE) && start && !abort)
            stall_cycles <= 32'd0;
        else if ((state == S_ISSUE) && !bus.row_ready)
            stall_cycles <= sat_inc32(stall_cycles);
    end
`endif

endmodule
